// File: rtl/alu_mult_seq.sv
// Shift-and-add multiplier sequencer that drives the shared datapath ALU over several cycles.
// Optional macro MULT_SEQ_GRANT_EN adds alu_grant, which stalls the ADD/SHIFT steps while low.
module alu_mult_seq #(
  parameter int         ITER_MAX = 32,
  parameter logic [3:0] OP_ADD   = 4'b0010,
  parameter logic [3:0] OP_SLL   = 4'b1110,
  parameter logic [3:0] OP_IDLE  = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  input  logic [31:0] alu_result,
`ifdef MULT_SEQ_GRANT_EN
  input  logic        alu_grant,
`endif
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_control,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_CHECK | decide: finish, add, or shift
  // S_ADD   | acc += mcand through the ALU
  // S_SHIFT | mcand <<= 1 through the ALU, mplier >>= 1
  // S_DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;
  logic        grant;

`ifdef MULT_SEQ_GRANT_EN
  assign grant = alu_grant;
`else
  assign grant = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    alu_rs      = '0;
    alu_rt      = '0;
    alu_shamt   = '0;
    alu_control = OP_IDLE;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = multiplicand;
          mplier_d = multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        // product loads here so it is already valid while done is high
        if (mplier_q == 32'd0 || cnt_q == 6'(ITER_MAX)) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else if (mplier_q[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADD: begin
        alu_control = OP_ADD;
        alu_rs      = acc_q;
        alu_rt      = mcand_q;
        if (grant) begin
          acc_d   = alu_result;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        alu_control = OP_SLL;
        alu_rt      = mcand_q;
        alu_shamt   = 5'd1;
        if (grant) begin
          mcand_d  = alu_result;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 6'd1;
          state_d  = S_CHECK;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq: vector table plus multi-cycle corner sequences.
module tb_alu_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand, multiplier, alu_result;
  logic [31:0] alu_rs, alu_rt, product;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_control;
  logic        busy, done;
`ifdef MULT_SEQ_GRANT_EN
  logic        alu_grant;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // reference ALU: add, shift-left-logical, otherwise AND
  assign alu_result = (alu_control == 4'b0010) ? alu_rs + alu_rt :
                      (alu_control == 4'b1110) ? alu_rt << alu_shamt :
                                                 alu_rs & alu_rt;

  alu_mult_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier), .alu_result(alu_result),
`ifdef MULT_SEQ_GRANT_EN
    .alu_grant(alu_grant),
`endif
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_shamt(alu_shamt), .alu_control(alu_control),
    .busy(busy), .done(done), .product(product)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    int          cyc;
  } vec_t;

  vec_t vecs[8];
  logic [3:0] ctrl_log[0:127];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called just after a negedge. Returns the cycle (after accept) in which done was seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int g_lo, input int g_hi,
                        output int cyc, output logic [31:0] prod, output bit saw_add,
                        output bit acc_moved);
    cyc = -1; prod = '0; saw_add = 1'b0; acc_moved = 1'b0;
    multiplicand = a; multiplier = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      ctrl_log[k[6:0]] = alu_control;
      if (alu_control == 4'b0010) saw_add = 1'b1;
      if (k >= g_lo + 1 && k <= g_hi + 1 && dut.acc_q != 32'd0) acc_moved = 1'b1;
`ifdef MULT_SEQ_GRANT_EN
      alu_grant = (k >= g_lo && k <= g_hi) ? 1'b0 : 1'b1;
`endif
      if (done) begin
        cyc = k; prod = product;
        break;
      end
    end
  endtask

  int          cyc;
  logic [31:0] prod;
  bit          saw_add, acc_moved, seen_done;
  logic [3:0]  exp_ctrl[1:10];

  initial begin
    vecs[0] = '{32'd3,        32'd5,        32'h0000000F, 10};
    vecs[1] = '{32'h1234,     32'd0,        32'h00000000, 2};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 98};
    vecs[3] = '{32'd7,        32'd7,        32'h00000031, 11};
    vecs[4] = '{32'd2,        32'd3,        32'h00000006, 8};
    vecs[5] = '{32'h80000000, 32'd2,        32'h00000000, 7};
    vecs[6] = '{32'h12345678, 32'd1,        32'h12345678, 5};
    vecs[7] = '{32'd5,        32'h80000000, 32'h80000000, 67};
    exp_ctrl = '{4'h0, 4'h2, 4'hE, 4'h0, 4'hE, 4'h0, 4'h2, 4'hE, 4'h0, 4'h0};

    reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
`ifdef MULT_SEQ_GRANT_EN
    alu_grant = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check((alu_rs | alu_rt | product) == 32'd0, "rst_data", alu_rs | alu_rt | product, 32'd0);
    check({busy, done, alu_shamt, alu_control} == 11'd0, "rst_ctrl",
          {21'd0, busy, done, alu_shamt, alu_control}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, -1, cyc, prod, saw_add, acc_moved);
      check(prod == vecs[i].p, $sformatf("vec%0d_product", i), prod, vecs[i].p);
      check(cyc == vecs[i].cyc, $sformatf("vec%0d_latency", i), cyc, vecs[i].cyc);
      if (i == 0)
        for (int c = 1; c <= 10; c++)
          check(ctrl_log[c] == exp_ctrl[c], $sformatf("ctrl_3x5_c%0d", c), {28'd0, ctrl_log[c]}, {28'd0, exp_ctrl[c]});
      if (i == 1) check(!saw_add, "zero_no_add", {31'd0, saw_add}, 32'd0);
      if (i == 2) check(dut.cnt_q == 6'd32, "wrap_cnt", {26'd0, dut.cnt_q}, 32'd32);
      @(negedge clk);
      check(!done && !busy, "done_one_cycle", {30'd0, done, busy}, 32'd0);
    end

    // busy rejection: start mid-run and during DONE are both dropped
    multiplicand = 32'd3; multiplier = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check(busy, "busy_rises", {31'd0, busy}, 32'd1);
    cyc = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) begin start = 1'b1; multiplicand = 32'd7; multiplier = 32'd7; end
      if (k == 6) start = 1'b0;
      if (done) begin
        cyc = k;
        start = 1'b1; multiplicand = 32'd7; multiplier = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        break;
      end
    end
    check(cyc == 10, "reject_latency", cyc, 32'd10);
    @(negedge clk);
    check(!busy && product == 32'h0F, "reject_product", product, 32'h0F);
    run_op(32'd7, 32'd7, 0, -1, cyc, prod, saw_add, acc_moved);
    check(prod == 32'h31, "after_reject_product", prod, 32'h31);
    @(negedge clk);

    // asynchronous reset during ADD
    multiplicand = 32'h10; multiplier = 32'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(alu_control == 4'b0010, "mid_in_add", {28'd0, alu_control}, 32'h2);
    #2 reset = 1'b1;
    #1;
    check((alu_rs | alu_rt | product) == 32'd0, "async_rst_data", alu_rs | alu_rt | product, 32'd0);
    check({busy, done, alu_shamt, alu_control} == 11'd0, "async_rst_ctrl",
          {21'd0, busy, done, alu_shamt, alu_control}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check(!seen_done, "abandoned_no_done", {31'd0, seen_done}, 32'd0);
    run_op(32'd2, 32'd3, 0, -1, cyc, prod, saw_add, acc_moved);
    check(prod == 32'd6, "post_reset_product", prod, 32'd6);
    @(negedge clk);

`ifdef MULT_SEQ_GRANT_EN
    run_op(32'd3, 32'd5, 1, 5, cyc, prod, saw_add, acc_moved);
    check(cyc == 14, "grant_latency", cyc, 32'd14);
    check(prod == 32'h0F, "grant_product", prod, 32'h0F);
    check(!acc_moved, "grant_acc_held", {31'd0, acc_moved}, 32'd0);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
